button_debounce: RTL and testbench
==================================

# button_debounce

Input-side companion to the board LED driver: conditions one raw mechanical push-button into clean, single-clock-domain events. Synchronises the asynchronous pin, rejects bounce with a stability counter and tracks state in a four-state FSM. Emits a debounced level, one-cycle press, release and long-press pulses, and a wrapping press counter for user logic that drives the LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised samples required to accept a change (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 50_000_000: hold time after `btn_press` before `btn_long` fires (1 s at 50 MHz); must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means `btn_in` = 0 is "pressed"; 0 means `btn_in` = 1 is "pressed".
- `clk`  input  1  system clock; all logic runs on its rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `btn_in`  input  1  raw button pin; asynchronous; may bounce.
- `btn_level`  output  1  debounced state; 1 = pressed, independent of `ACTIVE_LOW`.
- `btn_press`  output  1  one-cycle pulse when a press is accepted.
- `btn_release`  output  1  one-cycle pulse when a release is accepted.
- `btn_long`  output  1  one-cycle pulse, at most once per press, when the hold reaches `LONG_PRESS_CYCLES`.
- `press_count`  output  8  number of accepted presses, modulo 256.

## Operation
- Synchroniser: two flops; `btn_in` is normalised by `ACTIVE_LOW` to `raw_p` (1 = pressed) before the first flop. Both flops reset to 0 (released). Call the second flop's output `sync_p`.
- Stability counter: width `$clog2(LONG_PRESS_CYCLES+1)`. It is shared by debounce and hold timing, saturates and never wraps.
- FSM states are IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
  - IDLE: counter = 0. `sync_p`=1 → PRESS_WAIT with counter = 1.
  - PRESS_WAIT: `sync_p`=0 → IDLE with counter = 0 (glitch rejected, no output). `sync_p`=1 and counter = `DEBOUNCE_CYCLES`-1 → PRESSED with counter = 0, and `btn_press`, `btn_level` and `press_count` update on that edge. Otherwise the counter increments.
  - PRESSED: counter increments while `sync_p`=1, saturating at `LONG_PRESS_CYCLES`. `btn_long` pulses on the edge where the counter reaches `LONG_PRESS_CYCLES`. `sync_p`=0 → RELEASE_WAIT with counter = 1; the hold count is discarded.
  - RELEASE_WAIT: `sync_p`=1 → PRESSED with counter = 0. This is a bounce, not a new press: no pulse and `press_count` is unchanged. The long-press timer restarts, but `btn_long` stays suppressed if it has already fired for this press. `sync_p`=0 and counter = `DEBOUNCE_CYCLES`-1 → IDLE, with `btn_release` pulsing and `btn_level`=0.
- A `long_done` flag is set when `btn_long` fires and cleared on entry to IDLE.
- `press_count`: +1 on each `btn_press` edge; 255 → 0 wrap.
- All outputs are registered; there are no combinational paths from `btn_in`.

## Timing
- Reset (`rst_n`=0 at an edge): state = IDLE, counter = 0, synchroniser = 0, `long_done` = 0, and `btn_level`, `btn_press`, `btn_release`, `btn_long` = 0, `press_count` = 0. Reset has priority over every event, including mid-debounce and mid-hold.
- Press latency: if `raw_p` is first sampled 1 at edge E and stays 1, `btn_press`/`btn_level` go high after edge E+`DEBOUNCE_CYCLES`+1. `btn_press` drops after the next edge.
- Release latency is symmetric: `btn_release` is high after edge E+`DEBOUNCE_CYCLES`+1 from the first sampled 0.
- Long press: `btn_long` goes high exactly `LONG_PRESS_CYCLES` edges after the `btn_press` edge, provided `sync_p` stays 1. It is high for one cycle.
- `btn_press`, `btn_release` and `btn_long` are never high in the same cycle. `btn_press` and `btn_release` strictly alternate.
- A button held through reset deassertion is a new press, detected with normal press latency.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=16, `ACTIVE_LOW`=1.
- Clean press: `btn_in` 1→0 sampled at edge 10 and held → `btn_press`=1 after edge 15 only, `btn_level`=1, `press_count`=1.
- Bounce rejection: `btn_in` toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → no pulses, `btn_level`=0, `press_count`=0.
- Long press: hold pressed 30 cycles past `btn_press` → exactly one `btn_long`, 16 edges after `btn_press`. Then release → one `btn_release`, 5 edges after the first released sample.
- Release bounce: while PRESSED, a 2-cycle released glitch → no `btn_release`, `press_count` unchanged. A later clean release → single `btn_release`.
- Wrap: 256 clean press/release pairs → `press_count` returns to 0 and exactly 256 `btn_press` pulses are seen.
- Mid-press reset: `rst_n`=0 for 1 cycle during PRESS_WAIT and again during PRESSED → all outputs 0 the following cycle. With the button still held, a fresh `btn_press` follows after normal press latency.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce
//
// Conditions one raw mechanical push-button into clean events in the clk
// domain. The pin is synchronised and normalised to "1 = pressed". A
// four-state FSM with a shared saturating counter rejects bounce and times
// long holds. Every output is registered.
//
// Parameters
//   DEBOUNCE_CYCLES    stable synchronised samples needed to accept a change (>= 2)
//   LONG_PRESS_CYCLES  hold time after btn_press before btn_long (> DEBOUNCE_CYCLES)
//   ACTIVE_LOW         1: btn_in = 0 means pressed; 0: btn_in = 1 means pressed
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   btn_in       raw asynchronous button pin
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-cycle pulse on an accepted press
//   btn_release  one-cycle pulse on an accepted release
//   btn_long     one-cycle pulse, at most once per press, after a long hold
//   press_count  accepted presses, modulo 256
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | released and stable; counter held at 0
// PRESS_WAIT   | pressed samples seen, counting toward DEBOUNCE_CYCLES
// PRESSED      | press accepted; counter times the hold for btn_long
// RELEASE_WAIT | released samples seen, counting toward DEBOUNCE_CYCLES

module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_count
);

  localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          long_done, long_done_nxt;
  logic          level_nxt, press_nxt, release_nxt, long_nxt;
  logic [7:0]    count_nxt;
  logic          raw_p, sync_1, sync_p;

  // Polarity is normalised before the first flop so everything downstream
  // sees 1 = pressed.
  assign raw_p = ACTIVE_LOW ? ~btn_in : btn_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1      <= 1'b0;
      sync_p      <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      long_done   <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      press_count <= 8'd0;
    end else begin
      sync_1      <= raw_p;
      sync_p      <= sync_1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      long_done   <= long_done_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_long    <= long_nxt;
      press_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    long_done_nxt = long_done;
    level_nxt     = btn_level;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    long_nxt      = 1'b0;
    count_nxt     = press_count;

    case (state)
      IDLE: begin
        cnt_nxt       = '0;
        long_done_nxt = 1'b0;
        if (sync_p) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!sync_p) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          long_done_nxt = 1'b0;
        end else if (cnt == DB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
          count_nxt = press_count + 8'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sync_p) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end else if (cnt != LONG_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
          // long_done keeps a bounce-restarted hold from firing twice.
          if (cnt == LONG_LAST && !long_done) begin
            long_nxt      = 1'b1;
            long_done_nxt = 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        if (sync_p) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          release_nxt   = 1'b1;
          level_nxt     = 1'b0;
          long_done_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16,
// ACTIVE_LOW=1. Stimulus tasks push the expected pulse (kind, edge number,
// press_count) into a queue. A negedge monitor pops one entry per observed
// pulse and compares it.

module tb_button_debounce;

  localparam int DB = 4;
  localparam int LP = 16;
  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b1;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic       btn_long;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .press_count(press_count)
  );

  typedef struct {
    int kind;
    int edge_no;
    int cnt;
  } ev_t;

  ev_t sb[$];
  int  edge_n = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_count = 0;
  int  press_seen = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, $signed(got), $signed(exp), edge_n);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t ev;
    int  k;
    if (btn_press || btn_release || btn_long) begin
      if (btn_press) k = K_PRESS;
      else if (btn_release) k = K_RELEASE;
      else k = K_LONG;
      if (btn_press) press_seen++;
      if (sb.size() != 0) ev = sb.pop_front();
      else begin
        ev.kind    = -1;
        ev.edge_no = -1;
        ev.cnt     = -1;
      end
      chk("pulse_onehot", int'(btn_press) + int'(btn_release) + int'(btn_long), 1);
      chk("ev_kind", k, ev.kind);
      chk("ev_edge", edge_n, ev.edge_no);
      chk("ev_count", press_count, ev.cnt);
    end
  end

  task automatic push(input int kind, input int e, input int c);
    ev_t ev;
    ev.kind    = kind;
    ev.edge_no = e;
    ev.cnt     = c;
    sb.push_back(ev);
  endtask

  // Drives the pin on the next negedge; the following posedge is edge_n+1.
  task automatic set_btn(input bit pressed);
    @(negedge clk);
    btn_in = ~pressed;
  endtask

  task automatic wait_until(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, btn_level, 0);
    chk({tag, "_press"}, btn_press, 0);
    chk({tag, "_release"}, btn_release, 0);
    chk({tag, "_long"}, btn_long, 0);
    chk({tag, "_count"}, press_count, 0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    check_zero(tag);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int e, p, r, base;

    rst_n  = 1'b0;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Bounce: each level lasts only 2 samples, shorter than DB.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_in = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    btn_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("bounce_level", btn_level, 0);
    chk("bounce_count", press_count, 0);

    // Clean press held into a long press, with a bounce after btn_long
    // that must not produce a second btn_long.
    set_btn(1'b1);
    e = edge_n + 1;
    p = e + DB + 1;
    exp_count++;
    push(K_PRESS, p, exp_count);
    push(K_LONG, p + LP, exp_count);
    wait_until(p);
    chk("press_level", btn_level, 1);
    chk("press_count1", press_count, 1);
    wait_until(p + 1);
    chk("press_drop", btn_press, 0);
    wait_until(p + 19);
    set_btn(1'b0);
    @(negedge clk);
    set_btn(1'b1);
    wait_until(p + 45);
    chk("hold_level", btn_level, 1);
    set_btn(1'b0);
    r = edge_n + 1;
    push(K_RELEASE, r + DB + 1, exp_count);
    drain("drain_long", 40);
    chk("rel_level", btn_level, 0);

    // Release bounce while PRESSED, then clean release.
    set_btn(1'b1);
    e = edge_n + 1;
    p = e + DB + 1;
    exp_count++;
    push(K_PRESS, p, exp_count);
    wait_until(p + 3);
    set_btn(1'b0);
    @(negedge clk);
    set_btn(1'b1);
    wait_until(p + 14);
    chk("rbounce_level", btn_level, 1);
    chk("rbounce_count", press_count, 2);
    set_btn(1'b0);
    r = edge_n + 1;
    push(K_RELEASE, r + DB + 1, exp_count);
    drain("drain_rbounce", 40);

    // Wrap: 256 clean pairs from a freshly reset counter.
    do_reset(2, "wrap_rst");
    base = press_seen;
    for (int k = 0; k < 256; k++) begin
      set_btn(1'b1);
      e = edge_n + 1;
      exp_count = (exp_count + 1) % 256;
      push(K_PRESS, e + DB + 1, exp_count);
      repeat (8) @(negedge clk);
      set_btn(1'b0);
      r = edge_n + 1;
      push(K_RELEASE, r + DB + 1, exp_count);
      repeat (8) @(negedge clk);
    end
    drain("drain_wrap", 20);
    chk("wrap_presses", press_seen - base, 256);
    chk("wrap_count", press_count, 0);

    // Reset during PRESS_WAIT, then during PRESSED, button held throughout.
    set_btn(1'b1);
    e = edge_n + 1;
    wait_until(e + 2);
    do_reset(1, "rst_pw");
    e = edge_n + 1;
    p = e + DB + 1;
    exp_count++;
    push(K_PRESS, p, exp_count);
    wait_until(p + 5);
    chk("rst_pw_level", btn_level, 1);
    do_reset(1, "rst_pr");
    e = edge_n + 1;
    p = e + DB + 1;
    exp_count++;
    push(K_PRESS, p, exp_count);
    wait_until(p);
    chk("rst_pr_level", btn_level, 1);
    set_btn(1'b0);
    r = edge_n + 1;
    push(K_RELEASE, r + DB + 1, exp_count);
    drain("drain_rst", 40);
    chk("final_count", press_count, 1);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
